// File: rtl/cia_timer_gen.sv
// CIA-style interval timer: byte-lane latch, down-counter, control register and chainable underflow.
// Define CIA_TIMER_PBOUT_EN to build the PB-port pulse/toggle output; otherwise pb_out and pb_oe stay 0.
module cia_timer_gen #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clk7_en,
    input  logic               wr,
    input  logic [WIDTH/8-1:0] sel,
    input  logic               tcr,
    input  logic [7:0]         data_in,
    output logic [7:0]         data_out,
    input  logic               eclk,
    input  logic               cnt,
    input  logic               ufl_in,
    output logic               ufl_out,
    output logic               irq,
    output logic               pb_out,
    output logic               pb_oe
);
    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] latch_q, latch_d;
    logic [WIDTH-1:0] counter_q, counter_d;
    logic [6:0]       ctrl_q, ctrl_d;
    logic             top_load_q, top_load_d;
    logic             force_load_q, force_load_d;
    logic             cnt_s_q, cnt_prev_q;
    logic             count_en;
    logic             underflow;
    logic             tcr_wr;

    assign tcr_wr = wr & tcr;

    always_comb begin
        latch_d = latch_q;
        for (int i = 0; i < NB; i++) begin
            if (wr && sel[i]) begin
                latch_d[8*i +: 8] = data_in;
            end
        end
    end

    always_comb begin
        count_en = 1'b0;
        case (ctrl_q[6:5])
            2'b00:   count_en = eclk;
            2'b01:   count_en = cnt_s_q & ~cnt_prev_q;
            2'b10:   count_en = ufl_in;
            default: count_en = ufl_in & cnt;
        endcase
    end

    assign underflow = (counter_q == '0) & ctrl_q[0] & count_en;
    assign ufl_out   = underflow;
    assign irq       = underflow;

    // The top lane arms a load only while stopped or in one-shot, so a running
    // continuous timer picks up the new latch value at its next underflow instead.
    assign top_load_d   = wr & sel[NB-1] & (~ctrl_q[0] | ctrl_q[3]);
    assign force_load_d = tcr_wr & data_in[4];

    always_comb begin
        counter_d = counter_q;
        if (top_load_q || force_load_q || underflow) begin
            counter_d = latch_q;
        end else if (ctrl_q[0] && count_en) begin
            counter_d = counter_q - WIDTH'(1);
        end
    end

    always_comb begin
        ctrl_d = ctrl_q;
        if (tcr_wr) begin
            ctrl_d = {data_in[6:5], 1'b0, data_in[3:0]};
        end else if (top_load_q && ctrl_q[3]) begin
            ctrl_d[0] = 1'b1;
        end else if (underflow && ctrl_q[3]) begin
            ctrl_d[0] = 1'b0;
        end
    end

    always_comb begin
        data_out = 8'h00;
        if (!wr) begin
            for (int i = 0; i < NB; i++) begin
                if (sel[i]) begin
                    data_out = data_out | counter_q[8*i +: 8];
                end
            end
            if (tcr) begin
                data_out = data_out | {1'b0, ctrl_q};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clk7_en) begin
            if (!reset_n) begin
                latch_q      <= '1;
                counter_q    <= '1;
                ctrl_q       <= '0;
                top_load_q   <= 1'b0;
                force_load_q <= 1'b0;
                cnt_s_q      <= 1'b0;
                cnt_prev_q   <= 1'b0;
            end else begin
                latch_q      <= latch_d;
                counter_q    <= counter_d;
                ctrl_q       <= ctrl_d;
                top_load_q   <= top_load_d;
                force_load_q <= force_load_d;
                cnt_s_q      <= cnt;
                cnt_prev_q   <= cnt_s_q;
            end
        end
    end

`ifdef CIA_TIMER_PBOUT_EN
    logic pb_pulse_q;
    logic pb_toggle_q, pb_toggle_d;

    // Starting the timer from the bus presets the toggle output high.
    always_comb begin
        pb_toggle_d = pb_toggle_q;
        if (tcr_wr && data_in[0]) begin
            pb_toggle_d = 1'b1;
        end else if (underflow) begin
            pb_toggle_d = ~pb_toggle_q;
        end
    end

    always_ff @(posedge clk) begin
        if (clk7_en) begin
            if (!reset_n) begin
                pb_pulse_q  <= 1'b0;
                pb_toggle_q <= 1'b0;
            end else begin
                pb_pulse_q  <= underflow;
                pb_toggle_q <= pb_toggle_d;
            end
        end
    end

    assign pb_out = ctrl_q[2] ? pb_toggle_q : pb_pulse_q;
    assign pb_oe  = ctrl_q[1];
`else
    assign pb_out = 1'b0;
    assign pb_oe  = 1'b0;
`endif

endmodule

// File: tb/tb_cia_timer_gen.sv
// Directed bench for cia_timer_gen: vector table for the main modes plus hand sequences
// for chaining, mid-count reset, clock-enable hold and the PB output.
module tb_cia_timer_gen;

    typedef struct {
        logic       wr;
        logic [1:0] sel;
        logic       tcr;
        logic [7:0] din;
        logic       eclk;
        logic       cnt;
        logic [7:0] expDout;
        logic       expUfl;
    } vec_t;

    logic       clk = 1'b0;
    logic       resetN;
    logic       clk7En;
    logic       wr, tcr, eclk, cnt;
    logic [1:0] sel;
    logic [7:0] dataIn, dataOut;
    logic       uflOut, irq, pbOut, pbOe;

    logic       bWr, bTcr;
    logic [1:0] bSel;
    logic [7:0] bDataIn, bDataOut;
    logic       bUflOut, bIrq, bPbOut, bPbOe;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    cia_timer_gen #(.WIDTH(16)) dutA (
        .clk(clk), .reset_n(resetN), .clk7_en(clk7En),
        .wr(wr), .sel(sel), .tcr(tcr), .data_in(dataIn), .data_out(dataOut),
        .eclk(eclk), .cnt(cnt), .ufl_in(1'b0),
        .ufl_out(uflOut), .irq(irq), .pb_out(pbOut), .pb_oe(pbOe)
    );

    // Second instance counts underflows of the first to form a cascade.
    cia_timer_gen #(.WIDTH(16)) dutB (
        .clk(clk), .reset_n(resetN), .clk7_en(clk7En),
        .wr(bWr), .sel(bSel), .tcr(bTcr), .data_in(bDataIn), .data_out(bDataOut),
        .eclk(eclk), .cnt(1'b0), .ufl_in(uflOut),
        .ufl_out(bUflOut), .irq(bIrq), .pb_out(bPbOut), .pb_oe(bPbOe)
    );

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic w, input logic [1:0] s, input logic t, input logic [7:0] d);
        wr     = w;
        sel    = s;
        tcr    = t;
        dataIn = d;
    endtask

    task automatic applyStimulusB(input logic w, input logic [1:0] s, input logic t, input logic [7:0] d);
        bWr     = w;
        bSel    = s;
        bTcr    = t;
        bDataIn = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input logic w, input logic [1:0] s, input logic t, input logic [7:0] d,
                          input logic e, input logic c, input logic [7:0] eDout, input logic eUfl);
        vec_t v;
        v.wr = w; v.sel = s; v.tcr = t; v.din = d; v.eclk = e; v.cnt = c;
        v.expDout = eDout; v.expUfl = eUfl;
        vecs.push_back(v);
    endtask

    initial begin
        int uflHits;
        int bHits[$];
        logic prevUfl;

        resetN = 1'b0;
        clk7En = 1'b1;
        eclk   = 1'b0;
        cnt    = 1'b0;
        applyStimulus(1'b0, 2'b00, 1'b0, 8'h00);
        applyStimulusB(1'b0, 2'b00, 1'b0, 8'h00);

        // Continuous, latch 3: counter reads 3,2,1,0 with an underflow on 0.
        addVec(1, 2'b01, 0, 8'h03, 0, 0, 8'h00, 0);
        addVec(1, 2'b10, 0, 8'h00, 0, 0, 8'h00, 0);
        addVec(1, 2'b00, 1, 8'h01, 0, 0, 8'h00, 0);
        addVec(0, 2'b01, 0, 8'h00, 1, 0, 8'h03, 0);
        addVec(0, 2'b01, 0, 8'h00, 1, 0, 8'h02, 0);
        addVec(0, 2'b01, 0, 8'h00, 1, 0, 8'h01, 0);
        addVec(0, 2'b01, 0, 8'h00, 1, 0, 8'h00, 1);
        addVec(0, 2'b01, 0, 8'h00, 1, 0, 8'h03, 0);
        addVec(0, 2'b01, 0, 8'h00, 1, 0, 8'h02, 0);
        addVec(0, 2'b01, 0, 8'h00, 1, 0, 8'h01, 0);
        addVec(0, 2'b01, 0, 8'h00, 1, 0, 8'h00, 1);
        addVec(0, 2'b00, 1, 8'h00, 1, 0, 8'h01, 0);
        addVec(0, 2'b10, 0, 8'h00, 0, 0, 8'h00, 0);
        addVec(0, 2'b01, 0, 8'h00, 0, 0, 8'h02, 0);
        // One-shot: hi write self-starts, one underflow, START clears.
        addVec(1, 2'b00, 1, 8'h08, 0, 0, 8'h00, 0);
        addVec(1, 2'b01, 0, 8'h02, 0, 0, 8'h00, 0);
        addVec(1, 2'b10, 0, 8'h00, 1, 0, 8'h00, 0);
        addVec(0, 2'b00, 1, 8'h00, 1, 0, 8'h08, 0);
        addVec(0, 2'b00, 1, 8'h00, 1, 0, 8'h09, 0);
        addVec(0, 2'b01, 0, 8'h00, 1, 0, 8'h01, 0);
        addVec(0, 2'b01, 0, 8'h00, 1, 0, 8'h00, 1);
        addVec(0, 2'b00, 1, 8'h00, 1, 0, 8'h08, 0);
        addVec(0, 2'b01, 0, 8'h00, 1, 0, 8'h02, 0);
        // Force load through the LOAD strobe.
        addVec(1, 2'b01, 0, 8'h05, 1, 0, 8'h00, 0);
        addVec(1, 2'b00, 1, 8'h10, 1, 0, 8'h00, 0);
        addVec(0, 2'b01, 0, 8'h00, 1, 0, 8'h02, 0);
        addVec(0, 2'b01, 0, 8'h00, 1, 0, 8'h05, 0);
        addVec(0, 2'b00, 1, 8'h00, 1, 0, 8'h00, 0);
        // CNT rising edges, latch 4: underflow after the fifth edge, none while held high.
        addVec(1, 2'b01, 0, 8'h04, 1, 0, 8'h00, 0);
        addVec(1, 2'b10, 0, 8'h00, 1, 0, 8'h00, 0);
        addVec(1, 2'b00, 1, 8'h21, 1, 0, 8'h00, 0);
        addVec(0, 2'b01, 0, 8'h00, 1, 1, 8'h04, 0);
        addVec(0, 2'b01, 0, 8'h00, 1, 0, 8'h04, 0);
        addVec(0, 2'b01, 0, 8'h00, 1, 1, 8'h03, 0);
        addVec(0, 2'b01, 0, 8'h00, 1, 0, 8'h03, 0);
        addVec(0, 2'b01, 0, 8'h00, 1, 1, 8'h02, 0);
        addVec(0, 2'b01, 0, 8'h00, 1, 0, 8'h02, 0);
        addVec(0, 2'b01, 0, 8'h00, 1, 1, 8'h01, 0);
        addVec(0, 2'b01, 0, 8'h00, 1, 0, 8'h01, 0);
        addVec(0, 2'b01, 0, 8'h00, 1, 1, 8'h00, 0);
        addVec(0, 2'b01, 0, 8'h00, 1, 1, 8'h00, 1);
        addVec(0, 2'b01, 0, 8'h00, 1, 1, 8'h04, 0);
        addVec(0, 2'b01, 0, 8'h00, 1, 1, 8'h04, 0);
        addVec(1, 2'b00, 1, 8'h00, 0, 0, 8'h00, 0);

        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;

        applyStimulus(0, 2'b01, 0, 8'h00); #1; checkOutput("reset lo", dataOut, 8'hFF);
        applyStimulus(0, 2'b10, 0, 8'h00); #1; checkOutput("reset hi", dataOut, 8'hFF);
        applyStimulus(0, 2'b00, 1, 8'h00); #1; checkOutput("reset tcr", dataOut, 8'h00);
        applyStimulus(0, 2'b11, 0, 8'h00); #1; checkOutput("reset or lanes", dataOut, 8'hFF);
        applyStimulus(0, 2'b00, 0, 8'h00); #1; checkOutput("reset idle dout", dataOut, 8'h00);
        checkOutput("reset ufl", uflOut, 0);
        checkOutput("reset irq", irq, 0);
        checkOutput("reset pb", {pbOut, pbOe}, 0);
        tick();

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].wr, vecs[i].sel, vecs[i].tcr, vecs[i].din);
            eclk = vecs[i].eclk;
            cnt  = vecs[i].cnt;
            #1;
            checkOutput($sformatf("vec%0d dout", i), dataOut, vecs[i].expDout);
            checkOutput($sformatf("vec%0d ufl", i), uflOut, vecs[i].expUfl);
            checkOutput($sformatf("vec%0d irq", i), irq, vecs[i].expUfl);
            tick();
        end
        cnt  = 1'b0;
        eclk = 1'b0;

        // Cascade: A latch 1 continuous, B latch 2 counting A underflows.
        applyStimulus(1, 2'b01, 0, 8'h01); applyStimulusB(1, 2'b01, 0, 8'h02); tick();
        applyStimulus(1, 2'b10, 0, 8'h00); applyStimulusB(1, 2'b10, 0, 8'h00); tick();
        applyStimulus(1, 2'b00, 1, 8'h01); applyStimulusB(1, 2'b00, 1, 8'h41); tick();
        applyStimulus(0, 2'b00, 0, 8'h00); applyStimulusB(0, 2'b00, 1, 8'h00);
        #1;
        checkOutput("chain B tcr", bDataOut, 8'h41);
        applyStimulusB(0, 2'b00, 0, 8'h00);
        eclk = 1'b1;
        for (int i = 0; i < 30; i++) begin
            #1;
            checkOutput($sformatf("chain A ufl %0d", i), uflOut, (i % 2 == 1) ? 1 : 0);
            checkOutput($sformatf("chain B irq %0d", i), bIrq, bUflOut);
            if (bUflOut) bHits.push_back(i);
            tick();
        end
        checkOutput("chain B count", bHits.size(), 5);
        if (bHits.size() > 0) checkOutput("chain B first", bHits[0], 5);
        for (int i = 1; i < bHits.size(); i++) begin
            checkOutput($sformatf("chain B gap %0d", i), bHits[i] - bHits[i-1], 6);
        end

        // Mid-count reset with latch 0x1234.
        eclk = 1'b0;
        applyStimulusB(1, 2'b00, 1, 8'h00);
        applyStimulus(1, 2'b00, 1, 8'h00); tick();
        applyStimulusB(0, 2'b00, 0, 8'h00);
        applyStimulus(1, 2'b01, 0, 8'h34); tick();
        applyStimulus(1, 2'b10, 0, 8'h12); tick();
        applyStimulus(1, 2'b00, 1, 8'h01); tick();
        applyStimulus(0, 2'b00, 0, 8'h00);
        eclk = 1'b1;
        repeat (5) tick();
        resetN = 1'b0; tick();
        resetN = 1'b1;
        applyStimulus(0, 2'b01, 0, 8'h00); #1; checkOutput("midreset lo", dataOut, 8'hFF);
        applyStimulus(0, 2'b10, 0, 8'h00); #1; checkOutput("midreset hi", dataOut, 8'hFF);
        applyStimulus(0, 2'b00, 1, 8'h00); #1; checkOutput("midreset tcr", dataOut, 8'h00);
        applyStimulus(0, 2'b00, 0, 8'h00);
        uflHits = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (uflOut) uflHits++;
            tick();
        end
        checkOutput("midreset no ufl", uflHits, 0);

        // clk7_en low freezes the counter and ignores bus writes.
        eclk = 1'b0;
        applyStimulus(1, 2'b00, 1, 8'h01); tick();
        eclk = 1'b1;
        applyStimulus(0, 2'b01, 0, 8'h00); #1; checkOutput("en lo0", dataOut, 8'hFF);
        tick();
        checkOutput("en lo1", dataOut, 8'hFE);
        clk7En = 1'b0;
        applyStimulus(1, 2'b00, 1, 8'h00);
        repeat (3) tick();
        applyStimulus(0, 2'b00, 1, 8'h00); #1; checkOutput("en hold tcr", dataOut, 8'h01);
        applyStimulus(0, 2'b01, 0, 8'h00); #1; checkOutput("en hold lo", dataOut, 8'hFE);
        clk7En = 1'b1;
        tick();
        checkOutput("en resume lo", dataOut, 8'hFD);

        // PB output, latch 1, toggle mode with PBON.
        eclk = 1'b0;
        applyStimulus(1, 2'b00, 1, 8'h00); tick();
        applyStimulus(1, 2'b01, 0, 8'h01); tick();
        applyStimulus(1, 2'b10, 0, 8'h00); tick();
        eclk = 1'b1;
        applyStimulus(1, 2'b00, 1, 8'h07); tick();
        applyStimulus(0, 2'b00, 0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            #1;
`ifdef CIA_TIMER_PBOUT_EN
            checkOutput($sformatf("pb toggle %0d", i), pbOut, ((i / 2) % 2 == 0) ? 1 : 0);
            checkOutput($sformatf("pb oe %0d", i), pbOe, 1);
`else
            checkOutput($sformatf("pb off %0d", i), {pbOut, pbOe}, 0);
`endif
            tick();
        end
`ifdef CIA_TIMER_PBOUT_EN
        applyStimulus(1, 2'b00, 1, 8'h03);
        #1;
        prevUfl = uflOut;
        tick();
        applyStimulus(0, 2'b00, 0, 8'h00);
        uflHits = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            checkOutput($sformatf("pb pulse %0d", i), pbOut, prevUfl);
            if (pbOut) uflHits++;
            prevUfl = uflOut;
            tick();
        end
        checkOutput("pb pulse count", uflHits, 4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cia_timer_gen.md
# cia_timer_gen

Parametrised CIA-style interval timer: a down-counter of configurable width with byte-wide latches, a control register, one-shot or continuous run, selectable count source (E-clock, CNT pin edges, or an upstream timer underflow for chaining), and an optional PB-port output in pulse or toggle mode. It sits in the CIA block beside the existing timers. Chaining several instances builds 32-bit or wider timers and timer B/alarm-style cascades.

## Interface
- WIDTH, 16, counter and latch width in bits; a multiple of 8, from 8 to 32; NB = WIDTH/8 byte lanes
- clk  in  1  system clock
- reset_n  in  1  reset; **synchronous, active-low**
- clk7_en  in  1  clock enable; all state advances only when high
- wr  in  1  bus write strobe (read when low)
- sel  in  NB  one-hot byte-lane select for the latch/counter; bit 0 is LSB
- tcr  in  1  control register select
- data_in  in  8  bus write data
- data_out  out  8  bus read data; 0 when nothing is selected or wr=1
- eclk  in  1  E-clock count enable
- cnt  in  1  CNT pin level
- ufl_in  in  1  underflow from the upstream timer (chain input)
- ufl_out  out  1  underflow strobe, combinational, for the downstream timer
- irq  out  1  interrupt request, equal to ufl_out
- pb_out  out  1  PB port output value
- pb_oe  out  1  PB port output override (= control bit 1)

## Operation
- Control register (7 stored bits): b0 START, b1 PBON, b2 OUTMODE (0 pulse, 1 toggle), b3 RUNMODE (1 one-shot), b4 LOAD strobe (not stored, reads 0), b6:5 INMODE, b7 reads 0.
- INMODE gives count_en: 00 = eclk; 01 = rising edge of cnt (registered sample versus previous sample); 10 = ufl_in; 11 = ufl_in & cnt.
- Latch lane i is written when sel[i] & wr. Reset value of every latch byte: 0xFF.
- Writing the top lane (sel[NB-1]) while stopped or in one-shot registers top_load. In one-shot mode, top_load also sets START.
- Writing tcr with b4 = 1 registers force_load.
- underflow = (counter == 0) & START & count_en. This drives ufl_out and irq.
- Counter priority, highest first:
  - reset → all 1s
  - reload (top_load | force_load | underflow) → latch value
  - START & count_en → counter − 1, modulo 2^WIDTH
- Control priority, highest first:
  - reset → 0
  - tcr write → {data_in[6:5], 0, data_in[3:0]}
  - top_load & one-shot → START = 1
  - underflow & one-shot → START = 0
- Reads: a lane select returns the live counter byte. tcr returns {0, ctrl[6:0]}. If more than one select is high, the results are ORed.
- Reset values: data_out 0, ufl_out 0, irq 0, pb_out 0, pb_oe 0, counter all 1s, control 0.

## Timing
- top_load and force_load are registered. The counter takes the latch value on the first clk7_en cycle after the write.
- Underflow cycle: the counter reloads from the latch value as it was before any write in that same cycle.
- A top-lane write coinciding with underflow causes a second reload on the next enabled cycle, using the new latch value.
- Period in continuous mode is latch + 1 count_en pulses.
- A latch of 0 in continuous mode underflows on every count_en.
- CNT edge detection adds 1 enabled cycle of latency.
- A reset_n low mid-count clears everything on the next enabled edge. Pending top_load and force_load are discarded.
- If clk7_en is low, nothing changes, including edge-detect history.

## Configuration
- CIA_TIMER_PBOUT_EN defined: PB output logic is built.
  - Pulse mode: pb_out is high for exactly one clk7_en cycle, the cycle after underflow.
  - Toggle mode: pb_out inverts on each underflow (registered). A tcr write that sets START forces pb_out to 1.
- CIA_TIMER_PBOUT_EN undefined: pb_out = 0 and pb_oe = 0 at all times. Control bits 1 and 2 are still stored and readable; only the PB output is removed.

## Test plan
- WIDTH=16; latch 0x0003, continuous, INMODE 00, eclk=1 → ufl_out pulses every 4 enabled cycles. The counter reads 3, 2, 1, 0, 3…
- One-shot; write lo 0x02, then hi 0x00 → START sets itself. Exactly one underflow 4 enabled cycles after the hi write, then START reads 0.
- Two WIDTH=16 instances chained (B INMODE 10, B ufl_in = A ufl_out); A latch 0x0001, B latch 0x0002 → B underflows every 6 eclk cycles.
- INMODE 01; toggle cnt 5 times with latch 0x0004 → one underflow on the 5th rising edge. cnt held high → no count.
- With CIA_TIMER_PBOUT_EN, PBON=1, toggle mode, latch 0x0001 → pb_out = 1 at start, then inverts every 2 eclk cycles. Pulse mode → 1-cycle highs. Without the macro → pb_out stays 0.
- Assert reset_n low mid-count with the latch at 0x1234 → counter reads 0xFFFF and control reads 0x00. No ufl_out fires after release until START is written.
